// File: rtl/blake2_block_feeder.sv
// Packs a little-endian word stream into zero-padded Blake2 blocks with byte counter t and final flag.
// Optional input-qualifier checking (sticky err_o) is enabled by defining BLAKE2_FEEDER_ERR_EN.
module blake2_block_feeder #(
    parameter int W     = 64,
    parameter int BB    = 128,
    parameter int CNT_W = 64
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [W-1:0]            s_data_i,
    input  logic                    s_last_i,
    input  logic [$clog2(W/8):0]    s_bytes_i,
    output logic                    block_v_o,
    input  logic                    block_ready_i,
    output logic [BB*8-1:0]         block_o,
    output logic                    block_last_o,
`ifdef BLAKE2_FEEDER_ERR_EN
    output logic                    err_o,
`endif
    output logic [CNT_W-1:0]        block_cnt_o
);

    localparam int NB    = W / 8;
    localparam int NW    = BB * 8 / W;
    localparam int IDX_W = $clog2(NW);
    localparam int BW    = $clog2(NB) + 1;

    typedef enum logic [0:0] {FILL = 1'b0, EMIT = 1'b1} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BB*8-1:0]    block_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;
    logic               s_ready_q;
    logic               block_v_q;
    logic [W-1:0]       word_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               accept_s;

    // Padding bytes of the final word are forced to zero whatever the source drives.
    function automatic logic [W-1:0] mask_word(input logic [W-1:0] d,
                                               input logic         last,
                                               input logic [BW-1:0] n);
        logic [W-1:0] m;
        m = d;
        for (int b = 0; b < NB; b++) begin
            if (last && (b >= int'(n))) begin
                m[b*8 +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

    // Next-word datapath: masked word and running byte count.
    always_comb begin
        accept_s = s_valid_i & s_ready_q & (state_q == FILL);
        word_d   = mask_word(s_data_i, s_last_i, s_bytes_i);
        cnt_d    = cnt_q + CNT_W'(s_bytes_i);
    end

    // Fill/emit state machine owning the block buffer and all registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= FILL;
            idx_q     <= '0;
            block_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            s_ready_q <= 1'b1;
            block_v_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept_s) begin
                        block_q[idx_q*W +: W] <= word_d;
                        cnt_q                 <= cnt_d;
                        idx_q                 <= idx_q + IDX_W'(1);
                        if ((idx_q == IDX_W'(NW - 1)) || s_last_i) begin
                            state_q   <= EMIT;
                            s_ready_q <= 1'b0;
                            block_v_q <= 1'b1;
                            last_q    <= s_last_i;
                        end
                    end
                end
                EMIT: begin
                    if (block_ready_i) begin
                        state_q   <= FILL;
                        block_q   <= '0;
                        idx_q     <= '0;
                        s_ready_q <= 1'b1;
                        block_v_q <= 1'b0;
                        // Counter survives across blocks of one message, restarts after the last.
                        if (last_q) begin
                            cnt_q  <= '0;
                            last_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q   <= FILL;
                    idx_q     <= '0;
                    block_q   <= '0;
                    s_ready_q <= 1'b1;
                    block_v_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLAKE2_FEEDER_ERR_EN
    logic err_q;
    logic err_d;

    // Illegal byte-count qualifiers on an accepted word.
    always_comb begin
        err_d = 1'b0;
        if (accept_s) begin
            err_d = (s_bytes_i > BW'(NB))
                  | (!s_last_i && (s_bytes_i != BW'(NB)))
                  | (s_last_i && (s_bytes_i == BW'(0)) && (idx_q != IDX_W'(0)));
        end else begin
            err_d = 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign s_ready_o    = s_ready_q;
    assign block_v_o    = block_v_q;
    assign block_o      = block_q;
    assign block_last_o = last_q;
    assign block_cnt_o  = cnt_q;

endmodule

// File: tb/tb_blake2_block_feeder.sv
// Directed, table-driven bench for blake2_block_feeder (default W=64, BB=128, CNT_W=64).
module tb_blake2_block_feeder;

    logic           clk = 1'b0;
    logic           nreset;
    logic           s_valid_i;
    logic           s_ready_o;
    logic [63:0]    s_data_i;
    logic           s_last_i;
    logic [3:0]     s_bytes_i;
    logic           block_v_o;
    logic           block_ready_i;
    logic [1023:0]  block_o;
    logic           block_last_o;
    logic [63:0]    block_cnt_o;
`ifdef BLAKE2_FEEDER_ERR_EN
    logic           err_o;
`endif

    int total = 0;
    int bad   = 0;

    blake2_block_feeder dut (
        .clk           (clk),
        .nreset        (nreset),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .s_data_i      (s_data_i),
        .s_last_i      (s_last_i),
        .s_bytes_i     (s_bytes_i),
        .block_v_o     (block_v_o),
        .block_ready_i (block_ready_i),
        .block_o       (block_o),
        .block_last_o  (block_last_o),
`ifdef BLAKE2_FEEDER_ERR_EN
        .err_o         (err_o),
`endif
        .block_cnt_o   (block_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=running req=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [63:0] data;
        logic [3:0]  bytes;
        logic [63:0] exp_word;
        logic [63:0] exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic check_blk(input string name, input logic [1023:0] act, input logic [1023:0] req);
        int k;
        total++;
        if (act !== req) begin
            bad++;
            k = 0;
            for (int i = 15; i >= 0; i--) begin
                if (act[i*64 +: 64] !== req[i*64 +: 64]) k = i;
            end
            $display("FAIL %s word%0d act=%h req=%h", name, k, act[k*64 +: 64], req[k*64 +: 64]);
        end
    endtask

    // Offer one word; returns #1 after the edge at which it was accepted.
    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] n);
        int waitc;
        @(negedge clk);
        s_data_i  = d;
        s_last_i  = last;
        s_bytes_i = n;
        s_valid_i = 1'b1;
        waitc = 0;
        while (!s_ready_o && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=ready_low req=ready_high");
        end
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
    endtask

    // Called #1 after the completing word's accept edge: checks the block, then handshakes it.
    task automatic take_block(input string name, input logic [1023:0] exp_blk,
                              input logic [63:0] exp_cnt, input logic exp_last);
        check({name, "_valid"}, {63'd0, block_v_o}, 64'd1);
        check({name, "_ready_low"}, {63'd0, s_ready_o}, 64'd0);
        check_blk({name, "_block"}, block_o, exp_blk);
        check({name, "_cnt"}, block_cnt_o, exp_cnt);
        check({name, "_last"}, {63'd0, block_last_o}, {63'd0, exp_last});
        @(negedge clk);
        block_ready_i = 1'b1;
        @(posedge clk);
        #1;
        block_ready_i = 1'b0;
        check({name, "_released"}, {62'd0, block_v_o, s_ready_o}, 64'd1);
    endtask

    function automatic logic [63:0] pat(input int k);
        return 64'h0101010101010101 * 64'(k + 1);
    endfunction

    vec_t           vecs[5];
    logic [1023:0]  exp_blk;
    int             vcount;

    initial begin
        vecs[0] = '{"empty", 64'hDEADBEEF_DEADBEEF, 4'd0, 64'h0, 64'd0};
        vecs[1] = '{"abc",   64'hFFFFFFFF_FF636261, 4'd3, 64'h00000000_00636261, 64'd3};
        vecs[2] = '{"full8", 64'h01234567_89ABCDEF, 4'd8, 64'h01234567_89ABCDEF, 64'd8};
        vecs[3] = '{"one",   64'h55555555_55555511, 4'd1, 64'h00000000_00000011, 64'd1};
        vecs[4] = '{"seven", 64'h88776655_44332211, 4'd7, 64'h00776655_44332211, 64'd7};

        nreset        = 1'b0;
        s_valid_i     = 1'b0;
        s_data_i      = 64'd0;
        s_last_i      = 1'b0;
        s_bytes_i     = 4'd0;
        block_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, s_ready_o}, 64'd1);
        check("rst_valid", {63'd0, block_v_o}, 64'd0);
        check_blk("rst_block", block_o, 1024'd0);
        check("rst_cnt", block_cnt_o, 64'd0);
        check("rst_last", {63'd0, block_last_o}, 64'd0);
`ifdef BLAKE2_FEEDER_ERR_EN
        check("rst_err", {63'd0, err_o}, 64'd0);
`endif
        @(negedge clk);
        nreset = 1'b1;

        // Single-word messages from the table.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, 1'b1, vecs[i].bytes);
            exp_blk = 1024'd0;
            exp_blk[63:0] = vecs[i].exp_word;
            take_block(vecs[i].name, exp_blk, vecs[i].exp_cnt, 1'b1);
        end

        // 129-byte message: one full non-last block, then a one-byte final block.
        exp_blk = 1024'd0;
        for (int k = 0; k < 16; k++) begin
            send(pat(k), 1'b0, 4'd8);
            exp_blk[k*64 +: 64] = pat(k);
            if (k == 14) check("m129_not_yet", {63'd0, block_v_o}, 64'd0);
        end
        take_block("m129_b1", exp_blk, 64'd128, 1'b0);
        send(64'hFFFFFFFF_FFFFFFAA, 1'b1, 4'd1);
        take_block("m129_b2", 1024'hAA, 64'd129, 1'b1);
        send(64'hFFFFFFFF_FF636261, 1'b1, 4'd3);
        take_block("m129_next", 1024'h636261, 64'd3, 1'b1);

        // Exactly 128 bytes: a single final block and nothing after it.
        exp_blk = 1024'd0;
        for (int k = 0; k < 16; k++) begin
            send(pat(k + 3), (k == 15), 4'd8);
            exp_blk[k*64 +: 64] = pat(k + 3);
        end
        take_block("m128", exp_blk, 64'd128, 1'b1);
        vcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (block_v_o) vcount++;
        end
        check("m128_no_second", 64'(vcount), 64'd0);

        // Backpressure with a word offered during EMIT.
        send(64'hFFFFFFFF_FF636261, 1'b1, 4'd3);
        @(negedge clk);
        s_data_i  = 64'h11223344_5566BBAA;
        s_last_i  = 1'b1;
        s_bytes_i = 4'd2;
        s_valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_hold_vr", {62'd0, block_v_o, s_ready_o}, 64'd2);
            check_blk("bp_hold_block", block_o, 1024'h636261);
            check("bp_hold_cnt_last", {block_cnt_o[62:0], block_last_o}, 64'd7);
        end
        @(negedge clk);
        block_ready_i = 1'b1;
        @(posedge clk);
        #1;
        block_ready_i = 1'b0;
        check("bp_released", {62'd0, block_v_o, s_ready_o}, 64'd1);
        @(posedge clk);
        #1;
        s_valid_i = 1'b0;
        take_block("bp_word", 1024'hBBAA, 64'd2, 1'b1);

        // Asynchronous reset after 7 words, then a clean "abc".
        for (int k = 0; k < 7; k++) send(pat(k), 1'b0, 4'd8);
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("mr_ready_valid", {62'd0, s_ready_o, block_v_o}, 64'd2);
        check_blk("mr_block", block_o, 1024'd0);
        check("mr_cnt", block_cnt_o, 64'd0);
        check("mr_last", {63'd0, block_last_o}, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        send(64'hFFFFFFFF_FF636261, 1'b1, 4'd3);
        take_block("mr_abc", 1024'h636261, 64'd3, 1'b1);

`ifdef BLAKE2_FEEDER_ERR_EN
        check("err_clean", {63'd0, err_o}, 64'd0);
        send(64'hA1A2A3A4_A5A6A7A8, 1'b0, 4'd4);
        check("err_set", {63'd0, err_o}, 64'd1);
        send(64'hFFFFFFFF_FFFFFF77, 1'b1, 4'd1);
        exp_blk = 1024'd0;
        exp_blk[63:0]   = 64'hA1A2A3A4_A5A6A7A8;
        exp_blk[127:64] = 64'h77;
        take_block("err_blk", exp_blk, 64'd5, 1'b1);
        check("err_sticky", {63'd0, err_o}, 64'd1);
        @(negedge clk);
        nreset = 1'b0;
        #1;
        check("err_rst", {63'd0, err_o}, 64'd0);
        @(negedge clk);
        nreset = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
